ofm_wr_arbiter: RTL
===================

OFM_WR_ARBITER -- requirements
Module: ofm_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of OFM producer groups sharing the next-layer RAM write port.
REQ-002 Parameter ADDR_W, default 32, width of the next-layer RAM write address.
REQ-003 Parameter BURST_LEN, default 4, beats per granted burst; legal values 2..16.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req  input  NUM_REQ  per-producer request; held high until its burst completes.
REQ-007 layer_start  input  1  one-cycle pulse, loads start_addr into the write address counter.
REQ-008 start_addr  input  ADDR_W  first write address of the layer.
REQ-009 grant  output  NUM_REQ  one-hot owner of the current burst; all-zero when idle.
REQ-010 beat_sel  output  $clog2(BURST_LEN)  data-mux select, 0..BURST_LEN-1 within the burst.
REQ-011 wr_en  output  1  next-layer RAM write strobe.
REQ-012 wr_addr  output  ADDR_W  next-layer RAM write address for the current beat.
REQ-013 burst_done  output  1  one-cycle pulse on the last beat; qualifies which req is served via grant.
REQ-014 busy  output  1  high while in BURST.
REQ-015 start_err  output  1  sticky; set when layer_start arrives while busy.

Function
REQ-016 FSM states: IDLE, BURST; all outputs registered.
REQ-017 IDLE -> BURST on the edge after any req bit is high; grant, wr_en, busy rise one cycle after req (latency 1).
REQ-018 In BURST, wr_en=1 every cycle, beat_sel increments 0..BURST_LEN-1, wr_addr increments by 1 per beat.
REQ-019 On the cycle beat_sel=BURST_LEN-1, burst_done=1.
REQ-020 After the last beat: if any req other than the served one is high (or only the served one is high again), the next burst starts on the following cycle with no idle bubble; otherwise return to IDLE.
REQ-021 Round-robin: after serving index k, priority order is k+1, k+2, ..., k (mod NUM_REQ); after reset, pointer favours index 0.
REQ-022 A req deasserted mid-burst is ignored; the burst always completes BURST_LEN beats.
REQ-023 wr_addr wraps modulo 2^ADDR_W without flag.
REQ-024 layer_start in IDLE loads start_addr, taking effect on the next beat; if coincident with an IDLE->BURST transition, the first beat uses start_addr.
REQ-025 layer_start while busy is dropped, and start_err is set until reset.

Reset
REQ-026 On rst_n low: state=IDLE, grant=0, beat_sel=0, wr_en=0, wr_addr=0, burst_done=0, busy=0, start_err=0, RR pointer=index 0 highest.
REQ-027 Reset mid-burst aborts immediately; no further wr_en until a new request after reset release.

Configuration
REQ-028 Macro OFM_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority (lowest index wins, no pointer update); when undefined, round-robin per REQ-021.

Structure
REQ-029 Shared package holds the FSM state encoding (IDLE=0, BURST=1) and the default BURST_LEN/ADDR_W constants.
REQ-030 One sub-module, rr_arbiter (req, pointer -> one-hot grant), instantiated once; fixed-priority mode reuses it with pointer held at 0.

Verification
REQ-031 Single req=4'b0001, start_addr=0x100 pulsed in IDLE -> grant=0001 one cycle later, 4 wr_en beats at 0x100..0x103, beat_sel 0,1,2,3, burst_done on beat 3.
REQ-032 req=4'b1111 held -> grants 0001,0010,0100,1000,0001 back-to-back, 20 contiguous wr_en cycles, addresses contiguous.
REQ-033 Same as REQ-032 with OFM_ARB_FIXED_PRIO_EN -> grant stays 0001 for every burst.
REQ-034 wr_addr loaded 0xFFFFFFFE, one burst -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-035 layer_start pulsed on beat 1 of a burst -> address sequence unchanged, start_err=1 and remains set.
REQ-036 rst_n low on beat 2 -> all outputs zero asynchronously; after release with req=0010 -> new burst starts at wr_addr=0 with grant=0010.

Source files
------------

// File: rtl/ofm_wr_arbiter_pkg.sv
// Shared definitions for the OFM write-port arbiter: FSM encoding and default geometry.
package ofm_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int DEFAULT_BURST_LEN = 4;
    localparam int DEFAULT_ADDR_W    = 32;

endpackage

// File: rtl/ofm_wr_arbiter_rr.sv
// Rotating-priority arbiter: the first requester at or after ptr (modulo NUM_REQ) wins.
module rr_arbiter
    import ofm_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    // Outer loop walks priority order, inner loop maps offset to index with constant selects.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (((int'(ptr) + i) % NUM_REQ) == j)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ofm_wr_arbiter.sv
// Bursts of BURST_LEN beats from NUM_REQ producers onto one RAM write port with a shared address counter.
// Define OFM_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module ofm_wr_arbiter
    import ofm_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic                         layer_start,
    input  logic [ADDR_W-1:0]            start_addr,
    output logic [NUM_REQ-1:0]           grant,
    output logic [$clog2(BURST_LEN)-1:0] beat_sel,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         burst_done,
    output logic                         busy,
    output logic                         start_err
);

    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [ADDR_W-1:0]   addr_src;
    logic [PTR_W-1:0]    arb_ptr;
    logic [NUM_REQ-1:0]  arb_grant;
    logic                last_beat;
    logic                start_burst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (arb_ptr),
        .grant (arb_grant)
    );

    assign last_beat   = (beat_sel == BEAT_W'(BURST_LEN - 1));
    assign start_burst = (|req) && ((state == IDLE) || last_beat);
    // A layer_start coinciding with the first grant must steer that very first beat.
    assign addr_src    = ((state == IDLE) && layer_start) ? start_addr : addr_cnt;

`ifdef OFM_ARB_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] next_ptr;

    always_comb begin
        next_ptr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) next_ptr = PTR_W'((i + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (start_burst) begin
            rr_ptr <= next_ptr;
        end
    end

    assign arb_ptr = rr_ptr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            beat_sel   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            addr_cnt   <= '0;
            burst_done <= 1'b0;
            busy       <= 1'b0;
            start_err  <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            if (layer_start && (state == BURST)) start_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_burst) begin
                        state    <= BURST;
                        grant    <= arb_grant;
                        beat_sel <= '0;
                        wr_en    <= 1'b1;
                        busy     <= 1'b1;
                        wr_addr  <= addr_src;
                        addr_cnt <= addr_src + ADDR_W'(1);
                    end else if (layer_start) begin
                        addr_cnt <= start_addr;
                    end
                end
                BURST: begin
                    if (!last_beat) begin
                        beat_sel   <= beat_sel + 1'b1;
                        burst_done <= (beat_sel == BEAT_W'(BURST_LEN - 2));
                        wr_addr    <= addr_cnt;
                        addr_cnt   <= addr_cnt + ADDR_W'(1);
                    end else if (start_burst) begin
                        grant    <= arb_grant;
                        beat_sel <= '0;
                        wr_addr  <= addr_cnt;
                        addr_cnt <= addr_cnt + ADDR_W'(1);
                    end else begin
                        state    <= IDLE;
                        grant    <= '0;
                        beat_sel <= '0;
                        wr_en    <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
